// File: rtl/stream_source.sv
// stream_source: valid/ready burst generator emitting base, base+step, ...
// with optional idle gap after each accepted beat. All outputs registered.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SEND  | out_valid high, waiting for acceptance
// GAP   | idle cycles after a non-last beat before the next one
module stream_source #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] step,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] beats_sent
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] step_q, step_nx, data_nx;
  logic [CNT_W-1:0] count_q, count_nx, beats_nx, beats_inc;
  logic [GAP_W-1:0] gap_q, gap_nx, gap_cnt, gap_cnt_nx;
  logic             valid_nx, busy_nx, done_nx;
  logic             accept, last;

  // A beat moves only while valid is registered high, so ready is naturally
  // ignored in IDLE and GAP.
  assign accept    = out_valid && out_ready;
  assign beats_inc = beats_sent + CNT_W'(1);
  assign last      = (beats_inc == count_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start && (count != '0)) state_nx = SEND;
      SEND: begin
        if (accept) begin
          if (last)              state_nx = IDLE;
          else if (gap_q != '0)  state_nx = GAP;
        end
      end
      GAP:  if (gap_cnt == GAP_W'(1)) state_nx = SEND;
      default: state_nx = IDLE;
    endcase
  end

  // Next values for the registered outputs and latched burst fields
  always_comb begin
    valid_nx   = out_valid;
    data_nx    = out_data;
    busy_nx    = busy;
    done_nx    = 1'b0;
    beats_nx   = beats_sent;
    step_nx    = step_q;
    count_nx   = count_q;
    gap_nx     = gap_q;
    gap_cnt_nx = gap_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          beats_nx = '0;
          if (count != '0) begin
            step_nx  = step;
            count_nx = count;
            gap_nx   = gap;
            valid_nx = 1'b1;
            data_nx  = base;
            busy_nx  = 1'b1;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      SEND: begin
        if (accept) begin
          beats_nx = beats_inc;
          if (last) begin
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end else if (gap_q == '0) begin
            data_nx = out_data + step_q;
          end else begin
            valid_nx   = 1'b0;
            gap_cnt_nx = gap_q;
          end
        end
      end
      GAP: begin
        // Down-counter: the terminal count of 1 releases the next beat, so
        // valid stays low for exactly gap_q cycles.
        if (gap_cnt == GAP_W'(1)) begin
          valid_nx = 1'b1;
          data_nx  = out_data + step_q;
        end else begin
          gap_cnt_nx = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      beats_sent <= '0;
      step_q     <= '0;
      count_q    <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
    end else begin
      out_valid  <= valid_nx;
      out_data   <= data_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      beats_sent <= beats_nx;
      step_q     <= step_nx;
      count_q    <= count_nx;
      gap_q      <= gap_nx;
      gap_cnt    <= gap_cnt_nx;
    end
  end

endmodule

// File: tb/tb_stream_source.sv
// Bench for stream_source: directed scenarios plus randomized bursts, checked
// against the burst rules (word i = base + i*step, gap length, stability,
// done/busy/beats_sent) rather than a cycle-level copy of the design.
module tb_stream_source;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] base, step;
  logic [CNT_W-1:0] count;
  logic [GAP_W-1:0] gap;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             busy, done;
  logic [CNT_W-1:0] beats_sent;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_source #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .step(step),
    .count(count), .gap(gap), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done), .beats_sent(beats_sent)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one burst. For the first hold cycles after the start edge ready is
  // forced low, afterwards ready is high with probability pct percent.
  // Mid-burst, start is pulsed and the config inputs scrambled; neither may
  // affect the burst.
  task automatic run_burst(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] s,
                           input int c, input int g, input int pct, input int hold);
    int idx, cyc, idle;
    logic v, rdy;
    logic [WIDTH-1:0] w;
    start = 1'b1; base = b; step = s; count = CNT_W'(c); gap = GAP_W'(g);
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    base = $urandom; step = $urandom; count = CNT_W'($urandom_range(1, 9));
    gap = GAP_W'($urandom_range(0, 15));
    if (c == 0) begin
      chk("zero_done", {63'd0, done}, 64'd1);
      chk("zero_valid", {63'd0, out_valid}, 64'd0);
      chk("zero_busy", {63'd0, busy}, 64'd0);
      chk("zero_beats", {48'd0, beats_sent}, 64'd0);
      tick();
      chk("zero_done_pulse", {63'd0, done}, 64'd0);
      chk("zero_valid2", {63'd0, out_valid}, 64'd0);
      return;
    end
    chk("first_valid", {63'd0, out_valid}, 64'd1);
    chk("first_data", {32'd0, out_data}, {32'd0, b});
    chk("first_busy", {63'd0, busy}, 64'd1);
    chk("first_beats", {48'd0, beats_sent}, 64'd0);
    idx = 0; cyc = 0; idle = 0;
    while (idx < c && cyc < 400) begin
      rdy = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) < pct);
      out_ready = rdy;
      start = ($urandom_range(0, 3) == 0);
      base = $urandom;
      v = out_valid;
      tick();
      cyc++;
      w = b + s * WIDTH'(idx);
      if (v && rdy) begin
        idx++;
        w = b + s * WIDTH'(idx);
        chk("beats_sent", {48'd0, beats_sent}, 64'(idx));
        if (idx == c) begin
          chk("last_valid_low", {63'd0, out_valid}, 64'd0);
          chk("last_done", {63'd0, done}, 64'd1);
          chk("last_busy_low", {63'd0, busy}, 64'd0);
        end else begin
          chk("mid_done_low", {63'd0, done}, 64'd0);
          chk("mid_busy", {63'd0, busy}, 64'd1);
          idle = 0;
          if (g == 0) begin
            chk("b2b_valid", {63'd0, out_valid}, 64'd1);
            chk("b2b_data", {32'd0, out_data}, {32'd0, w});
          end else begin
            chk("gap_enter", {63'd0, out_valid}, 64'd0);
          end
        end
      end else if (v) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_data", {32'd0, out_data}, {32'd0, w});
      end else begin
        idle++;
        if (out_valid) begin
          chk("gap_len", 64'(idle), 64'(g));
          chk("gap_data", {32'd0, out_data}, {32'd0, w});
        end else begin
          chk("gap_short", {63'd0, idle < g}, 64'd1);
        end
      end
    end
    chk("burst_complete", 64'(idx), 64'(c));
    start = 1'b0; out_ready = 1'b1;
    tick();
    chk("after_done_low", {63'd0, done}, 64'd0);
    chk("after_busy_low", {63'd0, busy}, 64'd0);
    chk("after_valid_low", {63'd0, out_valid}, 64'd0);
    chk("after_beats", {48'd0, beats_sent}, 64'(c));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; step = '0; count = '0; gap = '0;
    out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_beats", {48'd0, beats_sent}, 64'd0);
    rst = 1'b0;
    tick();

    // back-to-back, always ready
    run_burst(32'h1111_1111, 32'h1111_1111, 3, 0, 100, 0);
    // backpressure: ready low for 3 cycles after first valid
    run_burst(32'h1111_1111, 32'h1111_1111, 3, 0, 100, 3);
    // gap of two cycles
    run_burst(32'd5, 32'd2, 2, 2, 100, 0);
    // zero count
    run_burst(32'hABCD_0000, 32'd1, 0, 0, 100, 0);
    // wrap-around
    run_burst(32'hFFFF_FFFF, 32'd1, 2, 0, 100, 0);
    // start directly in the cycle after done
    run_burst(32'd100, 32'd3, 1, 0, 100, 0);

    // start ignored while busy, then reset mid-burst
    start = 1'b1; base = 32'h1111_1111; step = 32'h1111_1111; count = 16'd5;
    gap = 4'd0; out_ready = 1'b0;
    tick();
    start = 1'b1; base = 32'hDEAD_BEEF; step = 32'd7; count = 16'd1;
    tick();
    start = 1'b0;
    chk("ign_valid", {63'd0, out_valid}, 64'd1);
    chk("ign_data", {32'd0, out_data}, 64'h1111_1111);
    out_ready = 1'b1;
    tick();
    chk("ign_step", {32'd0, out_data}, 64'h2222_2222);
    chk("ign_count_busy", {63'd0, busy}, 64'd1);
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_beats", {48'd0, beats_sent}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    chk("postrst_done", {63'd0, done}, 64'd0);
    chk("postrst_valid", {63'd0, out_valid}, 64'd0);
    run_burst(32'h1111_1111, 32'h1111_1111, 3, 0, 100, 0);

    // randomized bursts
    for (int n = 0; n < 12; n++) begin
      run_burst($urandom, $urandom, $urandom_range(0, 7), $urandom_range(0, 3),
                $urandom_range(40, 100), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
